instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Fetch stage upstream of the single-cycle controller/datapath. Holds the PC,
//   fetches each instruction from instruction memory over a req/ready handshake,
//   presents it (opcode/f3/f7 source) with instr_valid, and computes next PC
//   from controller pc_src once the core retires the instruction (advance).
// PARAMETERS
//   RESET_PC      32'h0000_0000  PC loaded on reset
//   TIMEOUT_CYC   16             max wait cycles for imem_ready before imem_timeout
//   TRAP_VECTOR   32'h0000_0100  redirect target for misaligned fetch (MISALIGN_TRAP_EN only)
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   rst             in   1   synchronous, active-high reset
//   pc_src          in   2   00 pc+4, 01 branch/jal target, 10 jalr target, 11 reserved (treated as 00)
//   branch_target   in   32  pc+imm from datapath
//   jalr_target     in   32  ALU result for jalr; bit0 forced to 0 before use
//   advance         in   1   core has executed current instr; commit next PC
//   imem_req        out  1   fetch request, held until imem_ready
//   imem_addr       out  32  fetch address (= pc), stable while imem_req
//   imem_ready      in   1   imem_rdata valid this cycle
//   imem_rdata      in   32  instruction word
//   instr           out  32  latched instruction
//   instr_valid     out  1   instr/pc hold a fetched instruction
//   pc              out  32  address of instr
//   pc_plus4        out  32  pc + 4 (jal/jalr link value)
//   imem_timeout    out  1   sticky: TIMEOUT_CYC expired in FETCH
//   misaligned      out  1   sticky misaligned-target flag (0 when feature off)
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0,
//     imem_timeout=0, misaligned=0, wait counter=0. Reset aborts any fetch;
//     outputs at reset values after the edge, imem_rdata that cycle discarded.
//   FSM IDLE -> FETCH (unconditional, 1 cycle after reset release).
//   FETCH: imem_req=1, imem_addr=pc. imem_ready=1 -> instr<=imem_rdata,
//     instr_valid<=1, counter<=0, go VALID. Else counter++; counter reaching
//     TIMEOUT_CYC-1 without ready sets imem_timeout (sticky), keeps requesting,
//     counter saturates. Ready on the same cycle as expiry still accepts data.
//   VALID: imem_req=0. advance=1 -> pc<=next_pc, instr_valid<=0, go FETCH.
//     advance=0 -> hold all. advance ignored in IDLE/FETCH.
//   Fetch latency: min 1 cycle FETCH + 1 cycle to VALID; back-to-back
//     throughput 1 instr / 2 cycles with zero-wait memory.
//   next_pc: 00/11 pc+4; 01 branch_target; 10 {jalr_target[31:1],1'b0}.
//     All adds mod 2^32 (pc=32'hFFFF_FFFC +4 wraps to 0, no flag).
//   pc_src/targets sampled only on the advance cycle in VALID.
//   imem_ready outside FETCH ignored.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: if next_pc[1:0]!=0 on advance, pc<=TRAP_VECTOR,
//     misaligned<=1 (sticky until rst).
//   Not defined: next_pc[1:0] forced to 2'b00 on load, misaligned tied 0.
// TESTING
//   rst 1 cycle, imem_ready=1 always -> imem_req at cycle 1, imem_addr=0,
//     instr_valid at cycle 2 with instr=imem_rdata.
//   VALID, pc=0x10, pc_src=01, branch_target=0x40, advance -> next imem_addr=0x40.
//   pc=0x20, pc_src=10, jalr_target=0x81, advance -> pc=0x80; pc_plus4 was 0x24.
//   imem_ready low 20 cycles (TIMEOUT_CYC=16) -> imem_timeout=1 at 16th FETCH
//     cycle, req held, ready then latches instr normally.
//   rst mid-FETCH with imem_ready=1 same cycle -> instr_valid=0, pc=RESET_PC.
//   MISALIGN_TRAP_EN: branch_target=0x42 -> pc=TRAP_VECTOR, misaligned=1;
//     without macro -> pc=0x40, misaligned=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
//============================================================================
// Module      : instruction_fetch_unit
// Description : PC register plus request/ready fetch FSM feeding the core.
//               Optional macro MISALIGN_TRAP_EN redirects misaligned next-PC
//               values to TRAP_VECTOR and raises a sticky misaligned flag.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pc_src_i,
   input  logic [31:0] branch_target_i,
   input  logic [31:0] jalr_target_i,
   input  logic        advance_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        imem_timeout_o,
   output logic        misaligned_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic             w_in_fetch;
   logic             w_fetch_done;
   logic             w_commit;
   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_next_pc;
   logic [31:0]      w_pc_load;
   logic [CNT_W:0]   w_cnt_inc;
   logic             w_expire;
   logic             w_unused;

   assign w_in_fetch   = (state_q == ST_FETCH);
   assign w_fetch_done = w_in_fetch && imem_ready_i;
   assign w_commit     = (state_q == ST_VALID) && advance_i;
   assign w_pc_plus4   = pc_q + 32'd4;

   // Counter value after this stalled cycle; expiry when it hits the limit.
   assign w_cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign w_expire  = (w_cnt_inc >= {1'b0, CNT_MAX});

   //------------------------------------------------------------------------
   // FSM: state register
   //------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   //------------------------------------------------------------------------
   // FSM: next state
   //------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: if (imem_ready_i) state_d = ST_VALID;
         ST_VALID: if (advance_i)    state_d = ST_FETCH;
         default:  state_d = ST_IDLE;
      endcase
   end

   //------------------------------------------------------------------------
   // FSM: outputs
   //------------------------------------------------------------------------
   always_comb begin
      imem_req_o = 1'b0;
      case (state_q)
         ST_FETCH: imem_req_o = 1'b1;
         default:  imem_req_o = 1'b0;
      endcase
   end

   //------------------------------------------------------------------------
   // Next-PC selection
   //------------------------------------------------------------------------
   always_comb begin
      w_next_pc = w_pc_plus4;
      case (pc_src_i)
         2'b01:   w_next_pc = branch_target_i;
         2'b10:   w_next_pc = {jalr_target_i[31:1], 1'b0};
         default: w_next_pc = w_pc_plus4;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic mis_q, mis_d;
   logic w_misalign;

   assign w_misalign = (w_next_pc[1:0] != 2'b00);
   assign w_pc_load  = w_misalign ? TRAP_VECTOR : w_next_pc;

   always_comb begin
      mis_d = mis_q;
      if (w_commit && w_misalign) begin
         mis_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign misaligned_o = mis_q;
   assign w_unused     = jalr_target_i[0];
`else
   // Low address bits are simply dropped when no trap is configured.
   assign w_pc_load    = w_next_pc & ~32'h0000_0003;
   assign misaligned_o = 1'b0;
   assign w_unused     = jalr_target_i[0] ^ (^TRAP_VECTOR);
`endif

   //------------------------------------------------------------------------
   // Datapath next-state
   //------------------------------------------------------------------------
   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;

      if (w_fetch_done) begin
         instr_d = imem_rdata_i;
         valid_d = 1'b1;
         cnt_d   = '0;
      end else if (w_in_fetch) begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = w_cnt_inc[CNT_W-1:0];
         end
         if (w_expire) begin
            timeout_d = 1'b1;
         end
      end

      if (w_commit) begin
         pc_d    = w_pc_load;
         valid_d = 1'b0;
      end
   end

   //------------------------------------------------------------------------
   // Datapath registers
   //------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0000_0000;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign imem_addr_o    = pc_q;
   assign instr_o        = instr_q;
   assign instr_valid_o  = valid_q;
   assign pc_o           = pc_q;
   assign pc_plus4_o     = w_pc_plus4;
   assign imem_timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
//============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Vector table, directed timeout sequence and randomized run
//               against a behavioural model of the fetch unit.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TO_CYC   = 16;
   localparam logic [31:0] TRAP     = 32'h0000_0100;

`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] PC_MIS = TRAP;
   localparam bit          EM     = 1'b1;
`else
   localparam logic [31:0] PC_MIS = 32'h0000_0040;
   localparam bit          EM     = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_src;
   logic [31:0] branch_target, jalr_target;
   logic        advance;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc, pc_plus4;
   logic        imem_timeout, misaligned;

   instruction_fetch_unit #(
      .RESET_PC    (RESET_PC),
      .TIMEOUT_CYC (TO_CYC),
      .TRAP_VECTOR (TRAP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_src_i        (pc_src),
      .branch_target_i (branch_target),
      .jalr_target_i   (jalr_target),
      .advance_i       (advance),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_ready_i    (imem_ready),
      .imem_rdata_i    (imem_rdata),
      .instr_o         (instr),
      .instr_valid_o   (instr_valid),
      .pc_o            (pc),
      .pc_plus4_o      (pc_plus4),
      .imem_timeout_o  (imem_timeout),
      .misaligned_o    (misaligned)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        r, a;
      logic [1:0]  s;
      logic [31:0] bt, jt;
      logic        rdy;
      logic [31:0] rd;
      logic [31:0] e_pc;
      logic        e_valid, e_req;
      logic [31:0] e_instr;
      logic        e_mis;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic a, input logic [1:0] s,
                               input logic [31:0] bt, input logic [31:0] jt,
                               input logic rdy, input logic [31:0] rd,
                               input logic [31:0] epc, input logic ev, input logic er,
                               input logic [31:0] ei, input logic em);
      vec_t v;
      v.r = r; v.a = a; v.s = s; v.bt = bt; v.jt = jt; v.rdy = rdy; v.rd = rd;
      v.e_pc = epc; v.e_valid = ev; v.e_req = er; v.e_instr = ei; v.e_mis = em;
      return v;
   endfunction

   vec_t tbl [25];

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_instr;
   bit          m_idle, m_fetch, m_valid, m_timeout, m_mis;
   int          m_wait;

   task automatic model_update();
      logic [31:0] t;
      if (rst) begin
         m_pc = RESET_PC; m_instr = 32'h0; m_idle = 1; m_fetch = 0; m_valid = 0;
         m_timeout = 0; m_mis = 0; m_wait = 0;
      end else if (m_idle) begin
         m_idle = 0; m_fetch = 1;
      end else if (m_fetch) begin
         if (imem_ready) begin
            m_instr = imem_rdata; m_valid = 1; m_fetch = 0; m_wait = 0;
         end else begin
            m_wait = m_wait + 1;
            if (m_wait >= TO_CYC - 1) m_timeout = 1;
         end
      end else if (m_valid && advance) begin
         case (pc_src)
            2'd1:    t = branch_target;
            2'd2:    t = jalr_target - (jalr_target % 2);
            default: t = m_pc + 32'd4;
         endcase
`ifdef MISALIGN_TRAP_EN
         if (t % 4 != 0) begin
            m_pc = TRAP; m_mis = 1;
         end else begin
            m_pc = t;
         end
`else
         m_pc = t - (t % 4);
`endif
         m_valid = 0; m_fetch = 1;
      end
   endtask

   task automatic model_check();
      chk("rnd_pc",       pc,                    m_pc);
      chk("rnd_pc_plus4", pc_plus4,              m_pc + 32'd4);
      chk("rnd_req",      {31'd0, imem_req},     {31'd0, m_fetch});
      if (m_fetch) chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_valid",    {31'd0, instr_valid},  {31'd0, m_valid});
      chk("rnd_instr",    instr,                 m_instr);
      chk("rnd_timeout",  {31'd0, imem_timeout}, {31'd0, m_timeout});
      chk("rnd_mis",      {31'd0, misaligned},   {31'd0, m_mis});
   endtask

   initial begin
      rst = 1'b1; pc_src = 2'd0; branch_target = 32'h0; jalr_target = 32'h0;
      advance = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;

      tbl[0]  = mk(1'b1,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,        32'h0,1'b0,1'b0,32'h0,1'b0);
      tbl[1]  = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'hBAD0BAD0, 32'h0,1'b0,1'b1,32'h0,1'b0);
      tbl[2]  = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'hAAAA0013, 32'h0,1'b1,1'b0,32'hAAAA0013,1'b0);
      tbl[3]  = mk(1'b0,1'b1,2'd1,32'h10,32'h0,1'b0,32'h0,       32'h10,1'b0,1'b1,32'hAAAA0013,1'b0);
      tbl[4]  = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h11,       32'h10,1'b1,1'b0,32'h11,1'b0);
      tbl[5]  = mk(1'b0,1'b0,2'd1,32'h0,32'h0,1'b1,32'h22,       32'h10,1'b1,1'b0,32'h11,1'b0);
      tbl[6]  = mk(1'b0,1'b1,2'd1,32'h40,32'h0,1'b0,32'h0,       32'h40,1'b0,1'b1,32'h11,1'b0);
      tbl[7]  = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,        32'h40,1'b0,1'b1,32'h11,1'b0);
      tbl[8]  = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h33,       32'h40,1'b1,1'b0,32'h33,1'b0);
      tbl[9]  = mk(1'b0,1'b1,2'd1,32'h20,32'h0,1'b0,32'h0,       32'h20,1'b0,1'b1,32'h33,1'b0);
      tbl[10] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h44,       32'h20,1'b1,1'b0,32'h44,1'b0);
      tbl[11] = mk(1'b0,1'b1,2'd2,32'h0,32'h81,1'b0,32'h0,       32'h80,1'b0,1'b1,32'h44,1'b0);
      tbl[12] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h55,       32'h80,1'b1,1'b0,32'h55,1'b0);
      tbl[13] = mk(1'b0,1'b1,2'd3,32'hDEAD,32'hBEEF,1'b0,32'h0,  32'h84,1'b0,1'b1,32'h55,1'b0);
      tbl[14] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h66,       32'h84,1'b1,1'b0,32'h66,1'b0);
      tbl[15] = mk(1'b0,1'b1,2'd1,32'h42,32'h0,1'b0,32'h0,       PC_MIS,1'b0,1'b1,32'h66,EM);
      tbl[16] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h77,       PC_MIS,1'b1,1'b0,32'h77,EM);
      tbl[17] = mk(1'b0,1'b1,2'd0,32'h0,32'h0,1'b0,32'h0,        PC_MIS+32'd4,1'b0,1'b1,32'h77,EM);
      tbl[18] = mk(1'b1,1'b0,2'd0,32'h0,32'h0,1'b1,32'h99,       32'h0,1'b0,1'b0,32'h0,1'b0);
      tbl[19] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h123,      32'h0,1'b0,1'b1,32'h0,1'b0);
      tbl[20] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,32'h0,        32'h0,1'b0,1'b1,32'h0,1'b0);
      tbl[21] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h1,        32'h0,1'b1,1'b0,32'h1,1'b0);
      tbl[22] = mk(1'b0,1'b1,2'd1,32'hFFFFFFFC,32'h0,1'b0,32'h0, 32'hFFFFFFFC,1'b0,1'b1,32'h1,1'b0);
      tbl[23] = mk(1'b0,1'b0,2'd0,32'h0,32'h0,1'b1,32'h2,        32'hFFFFFFFC,1'b1,1'b0,32'h2,1'b0);
      tbl[24] = mk(1'b0,1'b1,2'd0,32'h0,32'h0,1'b0,32'h0,        32'h0,1'b0,1'b1,32'h2,1'b0);

      foreach (tbl[i]) begin
         rst = tbl[i].r; advance = tbl[i].a; pc_src = tbl[i].s;
         branch_target = tbl[i].bt; jalr_target = tbl[i].jt;
         imem_ready = tbl[i].rdy; imem_rdata = tbl[i].rd;
         step();
         chk($sformatf("v%0d_pc", i),     pc,                   tbl[i].e_pc);
         chk($sformatf("v%0d_pc4", i),    pc_plus4,             tbl[i].e_pc + 32'd4);
         chk($sformatf("v%0d_valid", i),  {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
         chk($sformatf("v%0d_req", i),    {31'd0, imem_req},    {31'd0, tbl[i].e_req});
         chk($sformatf("v%0d_instr", i),  instr,                tbl[i].e_instr);
         chk($sformatf("v%0d_mis", i),    {31'd0, misaligned},  {31'd0, tbl[i].e_mis});
         chk($sformatf("v%0d_tmo", i),    {31'd0, imem_timeout}, 32'd0);
         if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_pc);
      end

      // Long stall: timeout becomes visible in the 16th fetch cycle.
      rst = 1'b1; advance = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
      step();
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("stall%0d_req", k), {31'd0, imem_req}, 32'd1);
         chk($sformatf("stall%0d_tmo", k), {31'd0, imem_timeout}, (k >= TO_CYC) ? 32'd1 : 32'd0);
      end
      imem_ready = 1'b1; imem_rdata = 32'hC0FFEE13;
      step();
      chk("stall_end_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_end_instr", instr, 32'hC0FFEE13);
      chk("stall_end_tmo",   {31'd0, imem_timeout}, 32'd1);
      rst = 1'b1;
      step();
      chk("stall_rst_tmo",   {31'd0, imem_timeout}, 32'd0);

      // Randomized run against the model.
      rst = 1'b1;
      model_update();
      step();
      model_check();
      for (int n = 0; n < 800; n++) begin
         rst           = ($urandom_range(0, 79) == 0);
         advance       = $urandom_range(0, 1) == 1;
         pc_src        = 2'($urandom_range(0, 3));
         branch_target = $urandom();
         jalr_target   = $urandom();
         if ($urandom_range(0, 1) == 1) branch_target[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1) jalr_target[1:0]   = 2'b00;
         imem_ready    = (n >= 300 && n < 400) ? ($urandom_range(0, 29) == 0)
                                               : ($urandom_range(0, 3) != 0);
         imem_rdata    = $urandom();
         model_update();
         step();
         model_check();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
